// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one external combinational WIDTH x WIDTH multiplier between NUM_REQ
//   requesters. Round-robin arbitration picks a winner in IDLE. The winner's
//   operands are registered onto mul_a/mul_b. The product is captured one cycle
//   later and held on a tagged valid/ready response channel.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   req_valid     per-requester operand valid           [NUM_REQ]
//   req_ready     per-requester accept, one-hot or zero [NUM_REQ]
//   req_a, req_b  flattened operands, requester i at [i*WIDTH +: WIDTH]
//   mul_a, mul_b  registered operands to the external multiplier
//   mul_product   combinational product from the multiplier
//   resp_valid    response valid; held with id/product until resp_ready
//   resp_ready    response consumer accept
//   resp_id       owner of resp_product
//   resp_product  registered full-width product
//   busy          state != IDLE
//
// The caller must choose ID_W so that 2**ID_W >= NUM_REQ.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  logic [2*WIDTH-1:0] resp_prod_q, resp_prod_d;
  logic               resp_vld_q, resp_vld_d;

  // Arbitration result
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [WIDTH-1:0]   win_a, win_b;
  int unsigned        arb_idx;

  // Search starts one past the last winner and wraps, so the last winner
  // has the lowest priority next time.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_a     = '0;
    win_b     = '0;
    arb_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = (32'(rr_ptr_q) + 32'(k)) % 32'(NUM_REQ);
      if (!win_found && req_valid[arb_idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(arb_idx);
        win_a     = req_a[arb_idx*WIDTH +: WIDTH];
        win_b     = req_b[arb_idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found) req_ready[win_id] = 1'b1;
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    resp_id_d   = resp_id_q;
    resp_prod_d = resp_prod_q;
    resp_vld_d  = resp_vld_q;
    case (state_q)
      IDLE: begin
        // A winner always has req_valid set and req_ready raised, so the
        // existence of a winner is the accept condition.
        if (win_found) begin
          state_d   = MUL;
          mul_a_d   = win_a;
          mul_b_d   = win_b;
          resp_id_d = win_id;
          rr_ptr_d  = win_id;
        end
      end
      MUL: begin
        resp_prod_d = mul_product;
        resp_vld_d  = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // Going back to IDLE first means the handshake cycle never accepts a request.
        if (resp_ready) begin
          resp_vld_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      resp_id_q   <= '0;
      resp_prod_q <= '0;
      resp_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      resp_id_q   <= resp_id_d;
      resp_prod_q <= resp_prod_d;
      resp_vld_q  <= resp_vld_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign resp_id      = resp_id_q;
  assign resp_product = resp_prod_q;
  assign resp_valid   = resp_vld_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter. The bench models the external multiplier.
// Inputs are driven and outputs are sampled 1ns+ after the rising edge.
module tb_mult_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a = '0;
  logic [NUM_REQ*WIDTH-1:0] req_b = '0;
  logic [WIDTH-1:0]         mul_a, mul_b;
  logic [2*WIDTH-1:0]       mul_product;
  logic                     resp_valid;
  logic                     resp_ready = 1'b1;
  logic [ID_W-1:0]          resp_id;
  logic [2*WIDTH-1:0]       resp_product;
  logic                     busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // External multiplier
  assign mul_product = mul_a * mul_b;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_mul_a",      32'(mul_a), 0);
    chk("rst_mul_b",      32'(mul_b), 0);
    chk("rst_resp_prod",  32'(resp_product), 0);
    chk("rst_resp_id",    32'(resp_id), 0);
    rst_n = 1'b1;
  endtask

  // One transaction: expected winner id, expected product; keep=1 leaves
  // the requester's valid asserted after it is accepted.
  task automatic serve(input int id, input logic [7:0] p, input bit keep);
    #1;
    chk($sformatf("grant%0d", id), 32'(req_ready), 32'(1) << id);
    tick();
    if (!keep) req_valid[id] = 1'b0;
    #1;
    chk("mul_ready_low", 32'(req_ready), 0);
    chk("mul_busy",      32'(busy), 1);
    chk("mul_rvalid",    32'(resp_valid), 0);
    tick();
    chk("resp_valid",    32'(resp_valid), 1);
    chk($sformatf("resp_id%0d", id), 32'(resp_id), 32'(id));
    chk($sformatf("resp_prod%0d", id), 32'(resp_product), 32'(p));
    tick();
    chk("resp_done", 32'(resp_valid), 0);
  endtask

  initial begin
    // 1: single request, 11*14 = 154
    do_reset();
    set_op(0, 4'b1011, 4'b1110);
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("t1_mul_a", 32'(mul_a), 32'hB);
    chk("t1_mul_b", 32'(mul_b), 32'hE);
    chk("t1_busy",  32'(busy), 1);
    tick();
    chk("t1_rvalid", 32'(resp_valid), 1);
    chk("t1_id",     32'(resp_id), 0);
    chk("t1_prod",   32'(resp_product), 32'h9A);
    tick();
    chk("t1_idle", 32'(busy), 0);

    // 2: all four valid, a=i+1, b=3
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd3);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) serve(i, 8'(3 * (i + 1)), 1'b0);

    // 3: backpressure while req1 waits (rr_ptr is 3, req0 wins)
    set_op(0, 4'd2, 4'd5);
    set_op(1, 4'd3, 4'd4);
    req_valid  = 4'b0001;
    resp_ready = 1'b0;
    #1 chk("t3_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", 32'(resp_valid), 1);
      chk("t3_hold_prod",  32'(resp_product), 32'h0A);
      chk("t3_hold_id",    32'(resp_id), 0);
      chk("t3_hold_ready", 32'(req_ready), 0);
      chk("t3_hold_busy",  32'(busy), 1);
      tick();
    end
    resp_ready = 1'b1;
    #1 chk("t3_hs_ready", 32'(req_ready), 0);
    tick();
    chk("t3_after_hs", 32'(resp_valid), 0);
    serve(1, 8'd12, 1'b0);

    // 4: boundary operands
    set_op(2, 4'd15, 4'd15);
    set_op(3, 4'd9, 4'd0);
    req_valid = 4'b1100;
    serve(2, 8'hE1, 1'b0);
    serve(3, 8'h00, 1'b0);

    // 5: reset in MUL aborts; afterwards req0 beats req3
    set_op(0, 4'd5, 4'd5);
    req_valid = 4'b0001;
    #1 chk("t5_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("t5_in_mul", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rvalid", 32'(resp_valid), 0);
    chk("t5_rst_busy",   32'(busy), 0);
    chk("t5_rst_mul_a",  32'(mul_a), 0);
    chk("t5_rst_prod",   32'(resp_product), 0);
    chk("t5_rst_id",     32'(resp_id), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("t5_no_resp", 32'(resp_valid), 0);
    set_op(0, 4'd2, 4'd7);
    set_op(3, 4'd6, 4'd6);
    req_valid = 4'b1001;
    serve(0, 8'd14, 1'b0);
    serve(3, 8'h24, 1'b0);

    // 6: req1/req2 alternate, then req3/req0 compete across the wrap
    set_op(1, 4'd1, 4'd7);
    set_op(2, 4'd2, 4'd6);
    req_valid = 4'b0110;
    serve(1, 8'd7, 1'b1);
    serve(2, 8'd12, 1'b1);
    serve(1, 8'd7, 1'b1);
    serve(2, 8'd12, 1'b1);
    set_op(0, 4'd3, 4'd3);
    set_op(3, 4'd4, 4'd4);
    req_valid = 4'b1001;
    serve(3, 8'h10, 1'b0);
    serve(0, 8'd9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
